match_sequencer: RTL and testbench

- Round/match controller that sequences the game scenes: welcome screen, pre-round countdown, fight, KO hold and match-over.
- Uses frame-rate timing and tracks round wins per player.
- Drives the background scene select, the player freeze, the per-round reset pulse and the death flags consumed by the sprite, health and background-mux logic.
- Replaces ad-hoc Enter-level scene switching with edge-detected, timed sequencing.

---
 rtl/game_pkg.sv | 35 +++
 rtl/key_edge_detect.sv | 47 ++++
 rtl/match_sequencer.sv | 299 +++++++++++++++++++++++++++++
 tb/tb_match_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the match sequencing logic.
//   match_state_t : round/match controller states
//   scene_t       : background scene select encoding
//   KEY_ENTER     : USB HID keycode for Enter (start / continue)
//   KEY_P         : USB HID keycode for 'P' (pause toggle, optional build)
//   wins_inc      : saturating increment for the 2-bit round-win counters
// ---------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      M_START,
      M_READY,
      M_FIGHT,
      M_KO,
      M_OVER
   } match_state_t;

   typedef enum logic [1:0] {
      SCENE_WELCOME = 2'd0,
      SCENE_ARENA   = 2'd1,
      SCENE_OVER    = 2'd2
   } scene_t;

   localparam logic [7:0] KEY_ENTER     = 8'h28;
   localparam logic [7:0] KEY_P         = 8'h13;
   localparam int         NUM_KEY_SLOTS = 4;

   // Win counters are 2 bits wide and stop at 3 rather than wrapping.
   function automatic logic [1:0] wins_inc(input logic [1:0] wins);
      return (wins == 2'd3) ? wins : wins + 2'd1;
   endfunction

endpackage

// File: rtl/key_edge_detect.sv
// ---------------------------------------------------------------------------
// key_edge_detect
// Scans the USB key slots for one keycode and flags the press edge.
//   clk   in  system clock
//   srst  in  synchronous active-high reset
//   keys  in  NUM_KEY_SLOTS x 8-bit current key slots
//   rise  out one-cycle pulse when KEY first appears in any slot
// The "seen last cycle" history is registered; rise is formed from the live
// slot match against that history so the controller can react with a single
// cycle of latency. A key held down never produces a second pulse.
// ---------------------------------------------------------------------------
module key_edge_detect
   import game_pkg::*;
#(
   parameter logic [7:0] KEY = KEY_ENTER
) (
   input  logic                          clk,
   input  logic                          srst,
   input  logic [NUM_KEY_SLOTS-1:0][7:0] keys,
   output logic                          rise
);

   logic [NUM_KEY_SLOTS-1:0] slot_hit;
   logic                     hit_now;
   logic                     hit_q;
   logic                     hit_d;

   for (genvar gi = 0; gi < NUM_KEY_SLOTS; gi++) begin : g_slot
      assign slot_hit[gi] = (keys[gi] == KEY);
   end

   assign hit_now = |slot_hit;
   assign rise    = hit_now & ~hit_q;

   always_comb begin
      hit_d = hit_now;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         hit_q <= 1'b0;
      end else begin
         hit_q <= hit_d;
      end
   end

endmodule

// File: rtl/match_sequencer.sv
// ---------------------------------------------------------------------------
// match_sequencer
// Round/match controller: welcome -> countdown -> fight -> KO hold -> over.
// Ports:
//   clk_25MHz          in   pixel/system clock
//   Reset              in   synchronous active-high reset
//   keycode..keycode3  in   USB key slots (8 bits each)
//   frame_tick         in   one pulse per frame
//   healthL, healthR   in   accumulated damage per player
//   scene              out  0=welcome 1=arena 2=over
//   startscreen/fighting/ending out one-hot state summary
//   freeze_players     out  inhibit movement and attacks
//   round_reset        out  one-cycle pulse clearing health and positions
//   deathL, deathR     out  round (or match) loser flags
//   countdown          out  seconds left in the pre-round countdown
//   round_time         out  seconds left in the fight
//   winsL, winsR       out  rounds won this match
//   paused             out  (only with MATCH_PAUSE_EN) fight is paused
// Optional build macro: MATCH_PAUSE_EN adds a 'P' pause toggle in FIGHT.
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module match_sequencer
   import game_pkg::*;
#(
   parameter int          FRAMES_PER_SEC    = 60,
   parameter int          ROUND_SECONDS     = 99,
   parameter int          COUNTDOWN_SECONDS = 3,
   parameter int          KO_HOLD_FRAMES    = 120,
   parameter int          ROUNDS_TO_WIN     = 2,
   parameter int          DEATH_THRESH      = 192,
   parameter logic [7:0]  ENTER_KEY         = KEY_ENTER
) (
   input  logic       clk_25MHz,
   input  logic       Reset,
   input  logic [7:0] keycode,
   input  logic [7:0] keycode1,
   input  logic [7:0] keycode2,
   input  logic [7:0] keycode3,
   input  logic       frame_tick,
   input  logic [7:0] healthL,
   input  logic [7:0] healthR,
   output logic [1:0] scene,
   output logic       startscreen,
   output logic       fighting,
   output logic       ending,
   output logic       freeze_players,
   output logic       round_reset,
   output logic       deathL,
   output logic       deathR,
   output logic [1:0] countdown,
   output logic [6:0] round_time,
   output logic [1:0] winsL,
`ifdef MATCH_PAUSE_EN
   output logic [1:0] winsR,
   output logic       paused
`else
   output logic [1:0] winsR
`endif
);

   localparam int FW = $clog2(FRAMES_PER_SEC + 1);
   localparam int HW = $clog2(KO_HOLD_FRAMES + 1);

   logic [NUM_KEY_SLOTS-1:0][7:0] key_slots;
   logic enter_rise;
   logic sec_tick;
   logic ko_l, ko_r;

   match_state_t state_q, state_d;
   scene_t       scene_q, scene_d;
   logic [FW-1:0] frame_q, frame_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [1:0] countdown_q, countdown_d;
   logic [6:0] round_time_q, round_time_d;
   logic [1:0] wins_l_q, wins_l_d, wins_r_q, wins_r_d;
   logic death_l_q, death_l_d, death_r_q, death_r_d;
   logic round_reset_q, round_reset_d;
   logic startscreen_q, startscreen_d, fighting_q, fighting_d;
   logic ending_q, ending_d, freeze_q, freeze_d;
   logic pause_q, pause_d;

   assign key_slots = {keycode3, keycode2, keycode1, keycode};

   key_edge_detect #(.KEY(ENTER_KEY)) u_enter_edge (
      .clk  (clk_25MHz),
      .srst (Reset),
      .keys (key_slots),
      .rise (enter_rise)
   );

`ifdef MATCH_PAUSE_EN
   logic p_rise;

   key_edge_detect #(.KEY(KEY_P)) u_pause_edge (
      .clk  (clk_25MHz),
      .srst (Reset),
      .keys (key_slots),
      .rise (p_rise)
   );

   // Pause only lives inside FIGHT; looking at the next state clears it in
   // the same cycle the fight ends (including a KO while paused).
   always_comb begin
      pause_d = pause_q;
      if (state_d != M_FIGHT) begin
         pause_d = 1'b0;
      end else if (p_rise) begin
         pause_d = ~pause_q;
      end
   end

   always_ff @(posedge clk_25MHz) begin
      if (Reset) begin
         pause_q <= 1'b0;
      end else begin
         pause_q <= pause_d;
      end
   end

   assign paused = pause_q;
`else
   assign pause_q = 1'b0;
   assign pause_d = 1'b0;
`endif

   // A paused fight stalls the frame counter, so no seconds elapse.
   assign sec_tick = frame_tick & ~pause_q & (frame_q == FW'(FRAMES_PER_SEC - 1));
   assign ko_l     = (healthL >= 8'(DEATH_THRESH));
   assign ko_r     = (healthR >= 8'(DEATH_THRESH));

   always_comb begin
      state_d       = state_q;
      countdown_d   = countdown_q;
      round_time_d  = round_time_q;
      wins_l_d      = wins_l_q;
      wins_r_d      = wins_r_q;
      death_l_d     = death_l_q;
      death_r_d     = death_r_q;
      round_reset_d = 1'b0;

      case (state_q)
         M_START: begin
            if (enter_rise) begin
               state_d       = M_READY;
               wins_l_d      = 2'd0;
               wins_r_d      = 2'd0;
               death_l_d     = 1'b0;
               death_r_d     = 1'b0;
               countdown_d   = 2'(COUNTDOWN_SECONDS);
               round_reset_d = 1'b1;
            end
         end
         M_READY: begin
            if (sec_tick) begin
               if (countdown_q == 2'd1) begin
                  state_d      = M_FIGHT;
                  countdown_d  = 2'd0;
                  round_time_d = 7'(ROUND_SECONDS);
               end else begin
                  countdown_d = countdown_q - 2'd1;
               end
            end
         end
         M_FIGHT: begin
            if (ko_l || ko_r) begin
               // KO wins over a simultaneous timeout; a double KO scores nobody.
               state_d   = M_KO;
               death_l_d = ko_l;
               death_r_d = ko_r;
               if (ko_r && !ko_l) wins_l_d = wins_inc(wins_l_q);
               if (ko_l && !ko_r) wins_r_d = wins_inc(wins_r_q);
            end else if (sec_tick) begin
               if (round_time_q == 7'd1) begin
                  // Timeout: the player with less damage takes the round.
                  state_d      = M_KO;
                  round_time_d = 7'd0;
                  death_l_d    = (healthL >= healthR);
                  death_r_d    = (healthR >= healthL);
                  if (healthL < healthR) wins_l_d = wins_inc(wins_l_q);
                  if (healthR < healthL) wins_r_d = wins_inc(wins_r_q);
               end else if (round_time_q != 7'd0) begin
                  round_time_d = round_time_q - 7'd1;
               end
            end
         end
         M_KO: begin
            if (frame_tick && (hold_q == HW'(KO_HOLD_FRAMES - 1))) begin
               if ((wins_l_q == 2'(ROUNDS_TO_WIN)) || (wins_r_q == 2'(ROUNDS_TO_WIN))) begin
                  state_d   = M_OVER;
                  death_l_d = (wins_r_q > wins_l_q);
                  death_r_d = (wins_l_q > wins_r_q);
               end else begin
                  state_d       = M_READY;
                  death_l_d     = 1'b0;
                  death_r_d     = 1'b0;
                  countdown_d   = 2'(COUNTDOWN_SECONDS);
                  round_reset_d = 1'b1;
               end
            end
         end
         M_OVER: begin
            if (enter_rise) begin
               state_d   = M_START;
               death_l_d = 1'b0;
               death_r_d = 1'b0;
            end
         end
         default: state_d = M_START;
      endcase

      // Frame and KO-hold counters restart on every state change so each
      // state measures its own time from entry.
      frame_d = frame_q;
      if (state_d != state_q) begin
         frame_d = '0;
      end else if (frame_tick && !pause_q) begin
         frame_d = sec_tick ? '0 : frame_q + FW'(1);
      end

      hold_d = hold_q;
      if (state_d != state_q) begin
         hold_d = '0;
      end else if ((state_q == M_KO) && frame_tick) begin
         hold_d = hold_q + HW'(1);
      end

      // Output decode from the next state so the summaries are registered.
      scene_d       = SCENE_ARENA;
      startscreen_d = 1'b0;
      fighting_d    = 1'b0;
      ending_d      = 1'b0;
      freeze_d      = 1'b1;
      case (state_d)
         M_START: begin
            scene_d       = SCENE_WELCOME;
            startscreen_d = 1'b1;
         end
         M_FIGHT: begin
            fighting_d = 1'b1;
            freeze_d   = pause_d;
         end
         M_OVER: begin
            scene_d  = SCENE_OVER;
            ending_d = 1'b1;
         end
         default: fighting_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk_25MHz) begin
      if (Reset) begin
         state_q       <= M_START;
         scene_q       <= SCENE_WELCOME;
         frame_q       <= '0;
         hold_q        <= '0;
         countdown_q   <= 2'd0;
         round_time_q  <= 7'd0;
         wins_l_q      <= 2'd0;
         wins_r_q      <= 2'd0;
         death_l_q     <= 1'b0;
         death_r_q     <= 1'b0;
         round_reset_q <= 1'b0;
         startscreen_q <= 1'b1;
         fighting_q    <= 1'b0;
         ending_q      <= 1'b0;
         freeze_q      <= 1'b1;
      end else begin
         state_q       <= state_d;
         scene_q       <= scene_d;
         frame_q       <= frame_d;
         hold_q        <= hold_d;
         countdown_q   <= countdown_d;
         round_time_q  <= round_time_d;
         wins_l_q      <= wins_l_d;
         wins_r_q      <= wins_r_d;
         death_l_q     <= death_l_d;
         death_r_q     <= death_r_d;
         round_reset_q <= round_reset_d;
         startscreen_q <= startscreen_d;
         fighting_q    <= fighting_d;
         ending_q      <= ending_d;
         freeze_q      <= freeze_d;
      end
   end

   assign scene          = scene_q;
   assign startscreen    = startscreen_q;
   assign fighting       = fighting_q;
   assign ending         = ending_q;
   assign freeze_players = freeze_q;
   assign round_reset    = round_reset_q;
   assign deathL         = death_l_q;
   assign deathR         = death_r_q;
   assign countdown      = countdown_q;
   assign round_time     = round_time_q;
   assign winsL          = wins_l_q;
   assign winsR          = wins_r_q;

endmodule

// File: tb/tb_match_sequencer.sv
// ---------------------------------------------------------------------------
// tb_match_sequencer
// Directed bench for match_sequencer: full match with KO, double KO, tied
// and decided timeouts, match-over, restart and mid-round reset. With
// MATCH_PAUSE_EN defined it also exercises the pause toggle.
// ---------------------------------------------------------------------------
module tb_match_sequencer;
   import game_pkg::*;

   localparam int FT_DIV = 2;   // clocks per frame_tick
   localparam int RS     = 3;   // round length used for this bench

   localparam int P_COUNTDOWN = 0, P_FREEZE = 1, P_DEATHL = 2, P_DEATHR = 3,
                  P_ENDING = 4, P_ROUNDTIME = 5;

   logic       clk = 1'b0;
   logic       Reset = 1'b1;
   logic [7:0] keycode = 8'h00, keycode1 = 8'h00, keycode2 = 8'h00, keycode3 = 8'h00;
   logic       frame_tick;
   logic [7:0] healthL = 8'd0, healthR = 8'd0;
   logic [1:0] scene, countdown, winsL, winsR;
   logic       startscreen, fighting, ending, freeze_players, round_reset, deathL, deathR;
   logic [6:0] round_time;
`ifdef MATCH_PAUSE_EN
   logic       paused;
`endif

   match_sequencer #(.ROUND_SECONDS(RS)) dut (
      .clk_25MHz      (clk),
      .Reset          (Reset),
      .keycode        (keycode),
      .keycode1       (keycode1),
      .keycode2       (keycode2),
      .keycode3       (keycode3),
      .frame_tick     (frame_tick),
      .healthL        (healthL),
      .healthR        (healthR),
      .scene          (scene),
      .startscreen    (startscreen),
      .fighting       (fighting),
      .ending         (ending),
      .freeze_players (freeze_players),
      .round_reset    (round_reset),
      .deathL         (deathL),
      .deathR         (deathR),
      .countdown      (countdown),
      .round_time     (round_time),
      .winsL          (winsL),
`ifdef MATCH_PAUSE_EN
      .winsR          (winsR),
      .paused         (paused)
`else
      .winsR          (winsR)
`endif
   );

   always #5 clk = ~clk;

   // Frame ticks; 'consumed' counts ticks already sampled by the DUT.
   int consumed = 0;
   int ft_phase = 0;
   initial begin
      frame_tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (frame_tick) consumed++;
         ft_phase   = (ft_phase + 1) % FT_DIV;
         frame_tick = (ft_phase == 0);
      end
   end

   int rr_pulses = 0;
   initial forever begin
      @(negedge clk);
      if (round_reset === 1'b1) rr_pulses++;
   end

   typedef struct {
      string tag;
      int    exp;
   } sb_t;

   sb_t sb_q[$];
   int  compared   = 0;
   int  mismatched = 0;

   task automatic push(input string tag, input int exp);
      sb_t e;
      e.tag = tag;
      e.exp = exp;
      sb_q.push_back(e);
   endtask

   task automatic check(input int obs);
      sb_t e;
      compared++;
      if (sb_q.size() == 0) begin
         mismatched++;
         $display("FAIL scoreboard_empty observed=%0d", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.exp) begin
            $display("check %-16s observed=%0d expected=%0d ok", e.tag, obs, e.exp);
         end else begin
            mismatched++;
            $display("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            $error("%s observed=%0d expected=%0d", e.tag, obs, e.exp);
         end
      end
   endtask

   function automatic int probe(input int sel);
      case (sel)
         P_COUNTDOWN: return int'(countdown);
         P_FREEZE:    return int'(freeze_players);
         P_DEATHL:    return int'(deathL);
         P_DEATHR:    return int'(deathR);
         P_ENDING:    return int'(ending);
         P_ROUNDTIME: return int'(round_time);
         default:     return -1;
      endcase
   endfunction

   task automatic wait_for(input int sel, input int val, input int budget, input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((probe(sel) != val) && (n < budget));
      if (probe(sel) != val) begin
         compared++;
         mismatched++;
         $display("FAIL timeout_%s observed=%0d expected=%0d", tag, probe(sel), val);
      end
   endtask

   int m1, m2, m3, r0;
`ifdef MATCH_PAUSE_EN
   int rt0;
`endif

   initial begin
      // Reset state
      repeat (5) @(negedge clk);
      push("rst_scene", 0);   check(int'(scene));
      push("rst_start", 1);   check(int'(startscreen));
      push("rst_fight", 0);   check(int'(fighting));
      push("rst_ending", 0);  check(int'(ending));
      push("rst_freeze", 1);  check(int'(freeze_players));
      push("rst_rr", 0);      check(int'(round_reset));
      push("rst_deathL", 0);  check(int'(deathL));
      push("rst_deathR", 0);  check(int'(deathR));
      push("rst_cd", 0);      check(int'(countdown));
      push("rst_rtime", 0);   check(int'(round_time));
      push("rst_winsL", 0);   check(int'(winsL));
      push("rst_winsR", 0);   check(int'(winsR));
      Reset = 1'b0;
      repeat (3) @(negedge clk);

      // Enter held for 10 frames -> exactly one round_reset
      push("enter_rr", 1); push("enter_cd", 3); push("enter_scene", 1);
      push("enter_freeze", 1); push("enter_start", 0);
      keycode2 = KEY_ENTER;
      @(negedge clk);
      check(int'(round_reset)); check(int'(countdown)); check(int'(scene));
      check(int'(freeze_players)); check(int'(startscreen));
      repeat (10 * FT_DIV) @(negedge clk);
      keycode2 = 8'h00;
      @(negedge clk);
      push("rr_count_1", 1); check(rr_pulses);

      // Countdown spacing and fight entry
      wait_for(P_COUNTDOWN, 2, 400, "cd2");
      m1 = consumed;
      wait_for(P_COUNTDOWN, 1, 400, "cd1");
      m2 = consumed;
      push("cd_spacing_a", 60); check(m2 - m1);
      wait_for(P_FREEZE, 0, 400, "fight1");
      m3 = consumed;
      push("cd_spacing_b", 60); check(m3 - m2);
      push("fight_rtime", RS); check(int'(round_time));
      push("fight_cd", 0);     check(int'(countdown));
      push("fight_flag", 1);   check(int'(fighting));

      // KO of player R
      push("ko_deathR", 1); push("ko_deathL", 0); push("ko_winsL", 1);
      push("ko_winsR", 0); push("ko_freeze", 1);
      healthR = 8'd192;
      @(negedge clk);
      check(int'(deathR)); check(int'(deathL)); check(int'(winsL));
      check(int'(winsR)); check(int'(freeze_players));
      m1 = consumed;
      healthR = 8'd0;
      wait_for(P_DEATHR, 0, 600, "ko_hold");
      m2 = consumed;
      push("ko_hold_ticks", 120); check(m2 - m1);
      push("ready2_cd", 3);       check(int'(countdown));
      @(negedge clk);
      push("rr_count_2", 2); check(rr_pulses);

      // Double KO
      wait_for(P_FREEZE, 0, 800, "fight2");
      push("dko_deathL", 1); push("dko_deathR", 1); push("dko_winsL", 1); push("dko_winsR", 0);
      healthL = 8'd200;
      healthR = 8'd195;
      @(negedge clk);
      check(int'(deathL)); check(int'(deathR)); check(int'(winsL)); check(int'(winsR));
      healthL = 8'd0;
      healthR = 8'd0;
      wait_for(P_DEATHL, 0, 600, "dko_hold");

      // Timeout with equal damage
      wait_for(P_FREEZE, 0, 800, "fight3");
      push("tie_rtime0", RS); check(int'(round_time));
      push("tie_deathR", 1); push("tie_winsL", 1); push("tie_winsR", 0); push("tie_rtime", 0);
      healthL = 8'd80;
      healthR = 8'd80;
      wait_for(P_DEATHL, 1, 1000, "tie_timeout");
      check(int'(deathR)); check(int'(winsL)); check(int'(winsR)); check(int'(round_time));
      healthL = 8'd0;
      healthR = 8'd0;
      wait_for(P_DEATHL, 0, 600, "tie_hold");

      // Timeout won by L -> second win -> match over
      wait_for(P_FREEZE, 0, 800, "fight4");
      push("to_deathL", 0); push("to_winsL", 2); push("to_winsR", 0);
      healthL = 8'd50;
      healthR = 8'd80;
      wait_for(P_DEATHR, 1, 1000, "l_timeout");
      check(int'(deathL)); check(int'(winsL)); check(int'(winsR));
      healthL = 8'd0;
      healthR = 8'd0;
      keycode = KEY_ENTER;   // held through KO -> OVER
      push("over_scene", 2); push("over_deathR", 1); push("over_deathL", 0);
      push("over_winsL", 2); push("over_freeze", 1);
      wait_for(P_ENDING, 1, 600, "over");
      check(int'(scene)); check(int'(deathR)); check(int'(deathL));
      check(int'(winsL)); check(int'(freeze_players));
      repeat (20) @(negedge clk);
      push("over_held", 1); check(int'(ending));
      keycode = 8'h00;
      repeat (2) @(negedge clk);

      // Enter -> START with wins shown, next Enter clears them
      push("restart_start", 1); push("restart_scene", 0);
      push("restart_winsL", 2); push("restart_ending", 0);
      keycode3 = KEY_ENTER;
      @(negedge clk);
      check(int'(startscreen)); check(int'(scene)); check(int'(winsL)); check(int'(ending));
      keycode3 = 8'h00;
      repeat (2) @(negedge clk);
      push("new_winsL", 0); push("new_winsR", 0); push("new_cd", 3); push("new_rr", 1);
      keycode1 = KEY_ENTER;
      @(negedge clk);
      check(int'(winsL)); check(int'(winsR)); check(int'(countdown)); check(int'(round_reset));
      keycode1 = 8'h00;

      // Reset in the middle of a countdown: back to START, no pulse
      wait_for(P_COUNTDOWN, 2, 400, "cd_before_rst");
      r0 = rr_pulses;
      Reset = 1'b1;
      repeat (3) @(negedge clk);
      Reset = 1'b0;
      repeat (2) @(negedge clk);
      push("mid_rst_start", 1); check(int'(startscreen));
      push("mid_rst_cd", 0);    check(int'(countdown));
      push("mid_rst_rr", r0);   check(rr_pulses);

`ifdef MATCH_PAUSE_EN
      // Pause toggle in FIGHT
      keycode = KEY_ENTER;
      @(negedge clk);
      keycode = 8'h00;
      wait_for(P_FREEZE, 0, 800, "fight_pause");
      push("pause_on", 1); push("pause_freeze", 1);
      keycode = KEY_P;
      @(negedge clk);
      check(int'(paused)); check(int'(freeze_players));
      rt0 = int'(round_time);
      repeat (300 * FT_DIV) @(negedge clk);
      push("pause_hold_rt", rt0); push("pause_hold_frz", 1);
      check(int'(round_time)); check(int'(freeze_players));
      keycode = 8'h00;
      @(negedge clk);
      push("pause_off", 0); push("resume_freeze", 0);
      keycode1 = KEY_P;
      @(negedge clk);
      check(int'(paused)); check(int'(freeze_players));
      keycode1 = 8'h00;
      wait_for(P_ROUNDTIME, rt0 - 1, 300, "resume_dec");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
